// File: rtl/branch_rs_if.sv
// Branch reservation station port bundle: dispatch, CDB snoop, issue, flush and occupancy.
// Latency: none (wires only).
// Backpressure: disp_valid/disp_ready and iss_valid/iss_ready handshakes carried as-is.
interface branch_rs_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
);
    // Dispatch side
    logic                         disp_valid;
    logic                         disp_ready;
    logic [9:0]                   disp_op;
    logic [XLEN-1:0]              disp_vj;
    logic [XLEN-1:0]              disp_vk;
    logic                         disp_rj;
    logic                         disp_rk;
    logic [TAG_W-1:0]             disp_qj;
    logic [TAG_W-1:0]             disp_qk;
    logic [TAG_W-1:0]             disp_rob;
    logic [XLEN-1:0]              disp_target;
    // Common data bus snoop
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [XLEN-1:0]              cdb_value;
    // Issue side towards the branch comparator
    logic                         iss_valid;
    logic                         iss_ready;
    logic [XLEN-1:0]              iss_vj;
    logic [XLEN-1:0]              iss_vk;
    logic [9:0]                   iss_op;
    logic [TAG_W-1:0]             iss_rob;
    logic [XLEN-1:0]              iss_target;
    // Recovery and status
    logic                         flush;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Core-side view: drives dispatch, CDB, issue acceptance and flush
    modport master (
        output disp_valid, disp_op, disp_vj, disp_vk, disp_rj, disp_rk,
               disp_qj, disp_qk, disp_rob, disp_target,
               cdb_valid, cdb_tag, cdb_value, iss_ready, flush,
        input  disp_ready, iss_valid, iss_vj, iss_vk, iss_op, iss_rob,
               iss_target, count
    );

    // Reservation-station view
    modport slave (
        input  disp_valid, disp_op, disp_vj, disp_vk, disp_rj, disp_rk,
               disp_qj, disp_qk, disp_rob, disp_target,
               cdb_valid, cdb_tag, cdb_value, iss_ready, flush,
        output disp_ready, iss_valid, iss_vj, iss_vk, iss_op, iss_rob,
               iss_target, count
    );
endinterface

// File: rtl/branch_rs.sv
// Collapsing-queue reservation station for branches; snoops CDB, presents oldest ready entry.
// Latency: dispatch->issue 1 cycle; CDB wakeup->issue 1 cycle (0 with BRANCH_RS_CDB_BYPASS_EN).
// Backpressure: disp_ready = count<DEPTH from registered state; entry held until iss_ready.
// Optional feature macro: BRANCH_RS_CDB_BYPASS_EN (same-cycle CDB bypass into issue selection).
module branch_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    branch_rs_if.slave   rs
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [9:0]       op;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic             rj;
        logic             rk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [TAG_W-1:0] rob;
        logic [XLEN-1:0]  target;
    } entry_t;

    // Registered state: slots 0..r_count-1 hold valid entries, slot 0 oldest
    entry_t           r_ent [DEPTH];
    logic [CNT_W-1:0] r_count;

    // Combinational helpers
    entry_t           w_wake [DEPTH];   // entries with this cycle's CDB wakeup applied
    entry_t           w_nxt  [DEPTH];   // next-state image of the queue
    entry_t           w_disp_ent;       // incoming entry after dispatch-time CDB capture
    entry_t           w_iss_ent;        // selected entry as presented to the comparator
    logic [DEPTH-1:0] w_rdy;
    logic             w_sel_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_iss_vld;
    logic             w_iss_fire;
    logic             w_disp_rdy;
    logic             w_disp_fire;
    logic [CNT_W-1:0] w_cnt_rm;

    assign w_disp_rdy  = (r_count < CNT_W'(DEPTH));
    assign w_iss_vld   = w_sel_found && !rs.flush;
    assign w_iss_fire  = w_iss_vld && rs.iss_ready;
    assign w_disp_fire = rs.disp_valid && w_disp_rdy && !rs.flush;
    assign w_cnt_rm    = r_count - CNT_W'(w_iss_fire);

    // Apply CDB wakeup to every stored entry and flag which valid slots are ready
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake[i] = r_ent[i];
            if (rs.cdb_valid && !r_ent[i].rj && (r_ent[i].qj == rs.cdb_tag)) begin
                w_wake[i].rj = 1'b1;
                w_wake[i].vj = rs.cdb_value;
            end
            if (rs.cdb_valid && !r_ent[i].rk && (r_ent[i].qk == rs.cdb_tag)) begin
                w_wake[i].rk = 1'b1;
                w_wake[i].vk = rs.cdb_value;
            end
`ifdef BRANCH_RS_CDB_BYPASS_EN
            // Same-cycle CDB matches count as ready
            w_rdy[i] = (CNT_W'(i) < r_count) && w_wake[i].rj && w_wake[i].rk;
`else
            // Only operands captured at an earlier edge count as ready
            w_rdy[i] = (CNT_W'(i) < r_count) && r_ent[i].rj && r_ent[i].rk;
`endif
        end
    end

    // Oldest-ready selection: scan from the top so the lowest ready index wins
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
`ifdef BRANCH_RS_CDB_BYPASS_EN
        w_iss_ent = w_wake[w_sel_idx];
`else
        w_iss_ent = r_ent[w_sel_idx];
`endif
    end

    // Incoming entry; a CDB broadcast in the dispatch cycle is captured here
    always_comb begin
        w_disp_ent.op     = rs.disp_op;
        w_disp_ent.vj     = rs.disp_vj;
        w_disp_ent.vk     = rs.disp_vk;
        w_disp_ent.rj     = rs.disp_rj;
        w_disp_ent.rk     = rs.disp_rk;
        w_disp_ent.qj     = rs.disp_qj;
        w_disp_ent.qk     = rs.disp_qk;
        w_disp_ent.rob    = rs.disp_rob;
        w_disp_ent.target = rs.disp_target;
        if (!rs.disp_rj && rs.cdb_valid && (rs.disp_qj == rs.cdb_tag)) begin
            w_disp_ent.rj = 1'b1;
            w_disp_ent.vj = rs.cdb_value;
        end
        if (!rs.disp_rk && rs.cdb_valid && (rs.disp_qk == rs.cdb_tag)) begin
            w_disp_ent.rk = 1'b1;
            w_disp_ent.vk = rs.cdb_value;
        end
    end

    // Next queue image: collapse above the issued slot, then append dispatch at the new tail
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_iss_fire && (IDX_W'(i) >= w_sel_idx)) begin
                if (i < DEPTH - 1) begin
                    w_nxt[i] = w_wake[i + 1];
                end else begin
                    w_nxt[i] = '0;
                end
            end else begin
                w_nxt[i] = w_wake[i];
            end
            // Keep unused slots clean so stale data never lingers past the tail
            if (CNT_W'(i) >= w_cnt_rm) begin
                w_nxt[i] = '0;
            end
            if (w_disp_fire && (CNT_W'(i) == w_cnt_rm)) begin
                w_nxt[i] = w_disp_ent;
            end
        end
    end

    // Queue state: reset and flush empty it, otherwise take the next image
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (rs.flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            r_count <= w_cnt_rm + CNT_W'(w_disp_fire);
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_nxt[i];
            end
        end
    end

    assign rs.disp_ready = w_disp_rdy;
    assign rs.count      = r_count;
    assign rs.iss_valid  = w_iss_vld;
    assign rs.iss_vj     = w_iss_vld ? w_iss_ent.vj     : '0;
    assign rs.iss_vk     = w_iss_vld ? w_iss_ent.vk     : '0;
    assign rs.iss_op     = w_iss_vld ? w_iss_ent.op     : '0;
    assign rs.iss_rob    = w_iss_vld ? w_iss_ent.rob    : '0;
    assign rs.iss_target = w_iss_vld ? w_iss_ent.target : '0;
endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: reset, oldest-ready issue, CDB wakeup and capture, full, flush, async reset.
// Latency: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: iss_ready driven explicitly per step; disp_ready checked at full.
module tb_branch_rs;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    branch_rs_if #(.DEPTH(4), .TAG_W(4), .XLEN(32)) bus ();

    branch_rs #(.DEPTH(4), .TAG_W(4), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Settle to the falling edge for sampling
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic disp(input logic [3:0] rob, input logic rj, input logic [3:0] qj,
                        input logic [31:0] vj, input logic rk, input logic [3:0] qk,
                        input logic [31:0] vk);
        bus.disp_valid  = 1'b1;
        bus.disp_op     = 10'b000_0000000;
        bus.disp_rob    = rob;
        bus.disp_rj     = rj;
        bus.disp_qj     = qj;
        bus.disp_vj     = vj;
        bus.disp_rk     = rk;
        bus.disp_qk     = qk;
        bus.disp_vk     = vk;
        bus.disp_target = 32'h1000 + {28'd0, rob};
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_vj = '0; bus.disp_vk = '0;
        bus.disp_rj = 1'b0; bus.disp_rk = 1'b0; bus.disp_qj = '0; bus.disp_qk = '0;
        bus.disp_rob = '0; bus.disp_target = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
        bus.iss_ready = 1'b0; bus.flush = 1'b0;

        // Reset state
        #2;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        chk("rst_iss_rob", 64'(bus.iss_rob), 64'd0);
        chk("rst_iss_vj", 64'(bus.iss_vj), 64'd0);
        chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        #6 rst_n = 1'b1;

        // Single ready BEQ: issues the cycle after dispatch
        cyc();
        disp(4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
        bus.iss_ready = 1'b1;
        smp();
        chk("t1_iss_valid_pre", 64'(bus.iss_valid), 64'd0);
        cyc();
        bus.disp_valid = 1'b0;
        smp();
        chk("t1_count_1", 64'(bus.count), 64'd1);
        chk("t1_iss_valid", 64'(bus.iss_valid), 64'd1);
        chk("t1_iss_rob", 64'(bus.iss_rob), 64'd3);
        chk("t1_iss_vj", 64'(bus.iss_vj), 64'd5);
        chk("t1_iss_target", 64'(bus.iss_target), 64'h1003);
        cyc();
        smp();
        chk("t1_count_0", 64'(bus.count), 64'd0);
        chk("t1_iss_valid_post", 64'(bus.iss_valid), 64'd0);
        chk("t1_iss_rob_zero", 64'(bus.iss_rob), 64'd0);

        // Older entry waits on tag 7, younger ready entry issues first
        cyc();
        bus.iss_ready = 1'b0;
        disp(4'd1, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd9);
        cyc();
        disp(4'd2, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
        cyc();
        bus.disp_valid = 1'b0;
        smp();
        chk("t2_count_2", 64'(bus.count), 64'd2);
        chk("t2_iss_rob_young", 64'(bus.iss_rob), 64'd2);
        bus.iss_ready = 1'b1;
        cyc();
        smp();
        chk("t2_count_1", 64'(bus.count), 64'd1);
        chk("t2_iss_valid_wait", 64'(bus.iss_valid), 64'd0);
        cyc();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd7; bus.cdb_value = 32'h10;
        smp();
`ifdef BRANCH_RS_CDB_BYPASS_EN
        chk("t2_byp_iss_valid", 64'(bus.iss_valid), 64'd1);
        chk("t2_byp_iss_rob", 64'(bus.iss_rob), 64'd1);
        chk("t2_byp_iss_vj", 64'(bus.iss_vj), 64'h10);
        cyc();
        bus.cdb_valid = 1'b0;
        smp();
        chk("t2_count_0", 64'(bus.count), 64'd0);
`else
        chk("t2_wake_iss_valid_same", 64'(bus.iss_valid), 64'd0);
        cyc();
        bus.cdb_valid = 1'b0;
        smp();
        chk("t2_wake_iss_valid", 64'(bus.iss_valid), 64'd1);
        chk("t2_wake_iss_rob", 64'(bus.iss_rob), 64'd1);
        chk("t2_wake_iss_vj", 64'(bus.iss_vj), 64'h10);
        chk("t2_wake_iss_vk", 64'(bus.iss_vk), 64'd9);
        cyc();
        smp();
        chk("t2_count_0", 64'(bus.count), 64'd0);
`endif

        // Dispatch-time CDB capture
        cyc();
        bus.iss_ready = 1'b0;
        disp(4'd5, 1'b0, 4'd4, 32'd0, 1'b1, 4'd0, 32'd3);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd4; bus.cdb_value = 32'hAB;
        smp();
        chk("t3_iss_valid_same", 64'(bus.iss_valid), 64'd0);
        cyc();
        bus.disp_valid = 1'b0; bus.cdb_valid = 1'b0;
        smp();
        chk("t3_iss_valid", 64'(bus.iss_valid), 64'd1);
        chk("t3_iss_vj", 64'(bus.iss_vj), 64'hAB);
        chk("t3_iss_rob", 64'(bus.iss_rob), 64'd5);
        bus.iss_ready = 1'b1;
        cyc();
        bus.iss_ready = 1'b0;
        smp();
        chk("t3_count_0", 64'(bus.count), 64'd0);

        // Fill to full, then issue with a blocked dispatch
        for (int k = 0; k < 4; k++) begin
            cyc();
            disp(4'(8 + k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'd0);
        end
        cyc();
        bus.disp_valid = 1'b0;
        smp();
        chk("t4_count_4", 64'(bus.count), 64'd4);
        chk("t4_disp_ready_full", 64'(bus.disp_ready), 64'd0);
        chk("t4_iss_rob_oldest", 64'(bus.iss_rob), 64'd8);
        cyc();
        bus.iss_ready = 1'b1;
        disp(4'd14, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        smp();
        chk("t4_disp_ready_still0", 64'(bus.disp_ready), 64'd0);
        cyc();
        bus.disp_valid = 1'b0; bus.iss_ready = 1'b0;
        smp();
        chk("t4_count_3", 64'(bus.count), 64'd3);
        chk("t4_disp_ready_1", 64'(bus.disp_ready), 64'd1);
        chk("t4_iss_rob_next", 64'(bus.iss_rob), 64'd9);

        // Add a waiting entry to reach four, then flush with dispatch, CDB and issue active
        cyc();
        disp(4'd12, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd0);
        cyc();
        bus.disp_valid = 1'b0;
        smp();
        chk("t5_count_4", 64'(bus.count), 64'd4);
        cyc();
        bus.flush = 1'b1; bus.iss_ready = 1'b1;
        disp(4'd13, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd2; bus.cdb_value = 32'h55;
        smp();
        chk("t5_flush_iss_valid", 64'(bus.iss_valid), 64'd0);
        cyc();
        bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.cdb_valid = 1'b0;
        smp();
        chk("t5_count_0", 64'(bus.count), 64'd0);
        chk("t5_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("t5_iss_valid_after", 64'(bus.iss_valid), 64'd0);
        cyc();
        smp();
        chk("t5_no_reappear", 64'(bus.iss_valid), 64'd0);

        // Flush beats a dispatch that would otherwise be accepted
        cyc();
        bus.iss_ready = 1'b0;
        disp(4'd6, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        cyc();
        bus.flush = 1'b1;
        disp(4'd7, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        cyc();
        bus.flush = 1'b0; bus.disp_valid = 1'b0;
        smp();
        chk("t5b_count_0", 64'(bus.count), 64'd0);

        // Asynchronous reset between edges with three entries
        for (int k = 0; k < 3; k++) begin
            cyc();
            disp(4'(1 + k), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        end
        cyc();
        bus.disp_valid = 1'b0;
        smp();
        chk("t6_count_3", 64'(bus.count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_count", 64'(bus.count), 64'd0);
        chk("t6_arst_iss_valid", 64'(bus.iss_valid), 64'd0);
        chk("t6_arst_disp_ready", 64'(bus.disp_ready), 64'd1);
        #1 rst_n = 1'b1;
        cyc();
        smp();
        chk("t6_post_count", 64'(bus.count), 64'd0);
        chk("t6_post_iss_valid", 64'(bus.iss_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_rs.md
# branch_rs

Reservation station for conditional branches in the out-of-order core. It buffers dispatched branch micro-ops and snoops the common data bus (CDB) for missing operands. Each cycle it presents the oldest fully-ready entry (Vj, Vk, Op, ROB tag, target) to the combinational branch comparator, and removes it on the issue handshake. A flush input discards all entries on misprediction recovery.

## Interface
- DEPTH, 4, number of entries (2..16)
- TAG_W, 4, ROB/CDB tag width
- XLEN, 32, operand and target width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry free; transfer when disp_valid && disp_ready
- disp_op  in  10  branch op; funct3 in [9:7]
- disp_vj, disp_vk  in  XLEN  operand values, valid when disp_rj / disp_rk = 1
- disp_rj, disp_rk  in  1  operand already available
- disp_qj, disp_qk  in  TAG_W  producer tag when operand not available
- disp_rob  in  TAG_W  ROB tag of the branch
- disp_target  in  XLEN  taken target PC
- cdb_valid  in  1  CDB broadcast
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  XLEN  broadcast value
- iss_valid  out  1  ready entry presented
- iss_ready  in  1  comparator path accepts
- iss_vj, iss_vk  out  XLEN  operands to comparator
- iss_op  out  10  op to comparator
- iss_rob  out  TAG_W  ROB tag
- iss_target  out  XLEN  target PC
- flush  in  1  synchronous clear of all entries
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Collapsing queue: valid entries occupy slots 0..count-1 in age order; slot 0 is oldest.
- Entry fields: op, vj, vk, rj, rk, qj, qk, rob, target.
- Dispatch: on handshake, the new entry is written at slot count after any same-cycle removal.
- Dispatch-time CDB capture (always present): if disp_rj=0 and cdb_valid and cdb_tag==disp_qj, store rj=1 and vj=cdb_value. Same for k.
- Wakeup: for every valid entry with rj=0 and qj==cdb_tag while cdb_valid, set rj=1 and vj=cdb_value. Same for k. Both operands may wake in the same cycle.
- Selection: iss_valid=1 when any entry has rj&&rk. The lowest-indexed such entry drives iss_*.
- Selection may change between cycles (e.g. an older entry wakes). No stability requirement.
- Issue: on iss_valid && iss_ready, the selected slot is removed and higher slots shift down one.
- Issue and dispatch in the same cycle are both honoured. Count is unchanged.
- disp_ready = (count < DEPTH), computed from registered state only. At full, a same-cycle issue does not raise it.
- iss_vj, iss_vk, iss_op, iss_rob and iss_target are driven 0 when iss_valid=0.
- Flush: at the edge all entries are invalidated and count goes to 0. Flush overrides a same-cycle dispatch, issue or wakeup. While flush=1, iss_valid is forced 0.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): count=0, all entries invalid, iss_valid=0, iss data=0, disp_ready=1.
- Reset mid-operation discards all entries immediately.
- Dispatch to earliest iss_valid with both operands ready: 1 cycle (visible the cycle after the dispatch edge).
- CDB wakeup to iss_valid: 1 cycle (default). See Configuration.
- Issue removal and shift complete at the handshake edge. The next selection is visible the following cycle.
- count updates at the edge: +1 on dispatch, -1 on issue, net 0 on both.

## Configuration
- BRANCH_RS_CDB_BYPASS_EN
  - Defined: an entry whose only outstanding operand(s) match cdb_tag while cdb_valid is treated as ready in the same cycle. Its iss_vj / iss_vk take cdb_value combinationally, giving 0-cycle wakeup-to-issue latency. Selection is still oldest-ready, counting bypass-ready entries. Bypass never applies to an entry being dispatched in that cycle.
  - Undefined: no combinational CDB path to iss_*. Wakeup-to-issue latency is 1 cycle.

## Test plan
- Reset, then dispatch BEQ op=10'b000_0000000, rj=rk=1, vj=vk=5, rob=3, iss_ready=1 -> iss_valid=1 with iss_rob=3 one cycle later; count 1->0 at the issue edge.
- Dispatch rob=1 with rj=0, qj=7; then dispatch rob=2 fully ready; iss_ready=1 -> rob=2 issues first. Then cdb_valid=1, tag=7, value=0x10 -> rob=1 issues with iss_vj=0x10 the next cycle (same cycle with BRANCH_RS_CDB_BYPASS_EN).
- Dispatch with rj=0, qj=4 in the same cycle as cdb_valid=1, tag=4, value=0xAB -> the entry is stored ready, and iss_vj=0xAB the next cycle.
- Fill DEPTH=4 entries with iss_ready=0 -> disp_ready=0, count=4. Assert iss_ready and disp_valid together -> one issue, no dispatch, count=3; disp_ready=1 next cycle.
- Four entries with mixed readiness; pulse flush alongside disp_valid and cdb_valid -> iss_valid=0 in that cycle; count=0, disp_ready=1 next cycle; no entry reappears.
- Assert rst_n=0 asynchronously between edges with 3 entries -> count=0 and iss_valid=0 immediately, without waiting for a clock edge.
